// File: rtl/keypad_pkg.sv
// Shared key codes, scan FSM state type and the default 4x4 key map.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR   = 4'hF;
  localparam logic [3:0] KEY_CONFIRM = 4'hE;
  localparam logic [3:0] KEY_NONE    = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } scan_state_t;

  // Rows 0..2 of columns 0..2 are the digits 1..9; row 3 holds CLEAR, 0, CONFIRM.
  // Column 3 and anything outside the 4x4 grid decode to NONE.
  function automatic logic [3:0] keymap(input int r, input int c);
    logic [3:0] code;
    code = KEY_NONE;
    if (r >= 0 && r < 3 && c >= 0 && c < 3) begin
      code = 4'(r * 3 + c + 1);
    end else if (r == 3) begin
      if (c == 0)      code = KEY_CLEAR;
      else if (c == 1) code = 4'd0;
      else if (c == 2) code = KEY_CONFIRM;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Keypad scanner: row synchroniser, scan tick divider and the scan/debounce FSM.
//
//   state      | meaning
//   S_IDLE     | all columns driven low, waiting for any row to go low
//   S_SCAN     | one column low at a time, locating the pressed key
//   S_DEBOUNCE | (row, col) latched, waiting for DEB_TICKS stable low samples
//   S_PRESSED  | key accepted, waiting for the row to go high
//   S_RELEASE  | row high, waiting for DEB_TICKS stable high samples
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            key_valid,
  output logic [3:0]      key_code
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LOAD = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LOAD  = DW'(DEB_TICKS - 1);

  logic [ROWS-1:0] row_meta, row_sync;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  scan_state_t     state, state_n;
  logic [CW-1:0]   col_idx, col_idx_n;
  logic [RW-1:0]   row_idx, row_idx_n, low_idx;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic            any_low, row_hit;
  logic            key_valid_n;
  logic [3:0]      key_code_n;
  logic [COLS-1:0] col_n;

  // Two-flop synchroniser; idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign tick = (tick_cnt == '0);

  // Down-counter producing a one-clk scan tick every SCAN_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= TICK_LOAD;
    else if (tick) tick_cnt <= TICK_LOAD;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // Lowest-index low row and whether the latched row is currently low.
  always_comb begin
    any_low = |(~row_sync);
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_sync[i]) low_idx = RW'(i);
    end
    row_hit = !row_sync[row_idx];
  end

  // FSM state, latched key position, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      col_idx   <= '0;
      row_idx   <= '0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      col       <= '1;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      deb_cnt   <= deb_n;
      key_valid <= key_valid_n;
      key_code  <= key_code_n;
      col       <= col_n;
    end
  end

  // Next-state logic; column drive is registered from the state being entered.
  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    row_idx_n   = row_idx;
    deb_n       = deb_cnt;
    key_valid_n = 1'b0;
    key_code_n  = key_code;

    if (!en) begin
      state_n = S_IDLE;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (any_low) begin
            state_n   = S_SCAN;
            col_idx_n = '0;
          end
        end
        S_SCAN: begin
          if (any_low) begin
            state_n   = S_DEBOUNCE;
            row_idx_n = low_idx;
            deb_n     = DEB_LOAD;
          end else if (col_idx == CW'(COLS - 1)) begin
            state_n = S_IDLE;
          end else begin
            col_idx_n = col_idx + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!row_hit) begin
            state_n = S_IDLE;
          end else if (deb_cnt == '0) begin
            state_n     = S_PRESSED;
            key_valid_n = 1'b1;
            key_code_n  = keymap(int'(row_idx), int'(col_idx));
          end else begin
            deb_n = deb_cnt - 1'b1;
          end
        end
        S_PRESSED: begin
          if (!row_hit) begin
            state_n = S_RELEASE;
            deb_n   = DEB_LOAD;
          end
        end
        S_RELEASE: begin
          if (row_hit) begin
            state_n = S_PRESSED;
          end else if (deb_cnt == '0) begin
            state_n = S_IDLE;
          end else begin
            deb_n = deb_cnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    col_n = '1;
    if (en) begin
      if (state_n == S_IDLE) col_n = '0;
      else                   col_n[col_idx_n] = 1'b0;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad front end: scanner plus saturating decimal entry and a circular commit history.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int VAL_W     = 10,
  parameter int DEPTH     = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ROWS-1:0]          row,
  output logic [COLS-1:0]          col,
  input  logic [VAL_W-1:0]         headroom,
  output logic                     key_valid,
  output logic [3:0]               key_code,
  output logic [VAL_W-1:0]         entry,
  output logic                     commit_valid,
  output logic [VAL_W-1:0]         commit_value,
  input  logic [$clog2(DEPTH)-1:0] hist_rd_idx,
  output logic [VAL_W-1:0]         hist_rd_data,
  output logic                     hist_rd_ok,
  output logic [$clog2(DEPTH):0]   hist_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int SW   = VAL_W + 4;

  logic [VAL_W-1:0] hist [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [SW-1:0]    digit_sum;
  logic [VAL_W-1:0] entry_clamped;
  logic [AW:0]      rd_sum;
  logic [AW-1:0]    rd_slot;

  keypad_scan #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SCAN_DIV  (SCAN_DIV),
    .DEB_TICKS (DEB_TICKS)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Appending a digit is done with 4 bits of headroom so the product never wraps.
  always_comb begin
    digit_sum     = {4'd0, entry} * SW'(10) + SW'(key_code);
    entry_clamped = (digit_sum > {4'd0, headroom}) ? headroom : digit_sum[VAL_W-1:0];
  end

  // Entry register and history ring, updated on the clock after each accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry        <= '0;
      commit_valid <= 1'b0;
      commit_value <= '0;
      wr_ptr       <= '0;
      hist_count   <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          entry <= entry_clamped;
        end else if (key_code == KEY_CLEAR) begin
          entry <= '0;
        end else if (key_code == KEY_CONFIRM && entry != '0) begin
          hist[wr_ptr] <= entry;
          commit_valid <= 1'b1;
          commit_value <= entry;
          wr_ptr       <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          if (hist_count != CNTW'(DEPTH)) hist_count <= hist_count + 1'b1;
          entry        <= '0;
        end
      end
    end
  end

  // Newest-first read: slot = (wr_ptr - 1 - idx) mod DEPTH, zero when idx is not stored.
  always_comb begin
    rd_sum       = {1'b0, wr_ptr} + CNTW'(DEPTH - 1) - {1'b0, hist_rd_idx};
    rd_slot      = (rd_sum >= CNTW'(DEPTH)) ? AW'(rd_sum - CNTW'(DEPTH)) : AW'(rd_sum);
    hist_rd_ok   = ({1'b0, hist_rd_idx} < hist_count);
    hist_rd_data = '0;
    if (hist_rd_ok) hist_rd_data = hist[rd_slot];
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: keypad matrix model, queue-based entry/history model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_keypad_entry_ctrl;

  localparam int ROWS = 4, COLS = 4, VAL_W = 10, DEPTH = 4;
  localparam int SCAN_DIV = 4, DEB_TICKS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [VAL_W-1:0] headroom;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [VAL_W-1:0] entry;
  logic             commit_valid;
  logic [VAL_W-1:0] commit_value;
  logic [1:0]       hist_rd_idx;
  logic [VAL_W-1:0] hist_rd_data;
  logic             hist_rd_ok;
  logic [2:0]       hist_count;

  keypad_entry_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .VAL_W(VAL_W), .DEPTH(DEPTH),
    .SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .row(row), .col(col), .headroom(headroom),
    .key_valid(key_valid), .key_code(key_code), .entry(entry),
    .commit_valid(commit_valid), .commit_value(commit_value),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data),
    .hist_rd_ok(hist_rd_ok), .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven low.
  int press_r = 0, press_c = 0;
  bit press_on = 0;
  always_comb begin
    row = '1;
    if (press_on && !col[press_c]) row[press_r] = 1'b0;
  end

  // Legend printed on the keys, row-major.
  int key_tab [4][4] = '{'{1, 2, 3, 13}, '{4, 5, 6, 13}, '{7, 8, 9, 13}, '{15, 0, 14, 13}};

  int n_cmp = 0, n_fail = 0;
  int kv_count = 0, cv_count = 0;
  int exp_code = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: entry value, newest-first history queue, pending commit.
  int m_entry = 0;
  int m_hist[$];
  bit m_pend = 0;
  int m_pend_val = 0;
  int en_low = 0;

  always @(negedge clk) begin : cmp
    int idx, exp_rd, t;
    if (rst) begin
      m_entry = 0;
      m_hist.delete();
      m_pend = 0;
      en_low = 0;
    end else begin
      chk("entry", int'(entry), m_entry);
      chk("commit_valid", int'(commit_valid), int'(m_pend));
      if (m_pend) chk("commit_value", int'(commit_value), m_pend_val);
      if (commit_valid) cv_count++;
      chk("hist_count", int'(hist_count), m_hist.size());
      idx = int'(hist_rd_idx);
      exp_rd = (idx < m_hist.size()) ? m_hist[idx] : 0;
      chk("hist_rd_ok", int'(hist_rd_ok), (idx < m_hist.size()) ? 1 : 0);
      chk("hist_rd_data", int'(hist_rd_data), exp_rd);
      en_low = en ? 0 : en_low + 1;
      if (en_low >= 2) chk("col_disabled", int'(col), 15);
      m_pend = 0;
      if (key_valid) begin
        kv_count++;
        chk("key_code", int'(key_code), exp_code);
        if (exp_code <= 9) begin
          t = m_entry * 10 + exp_code;
          m_entry = (t > int'(headroom)) ? int'(headroom) : t;
        end else if (exp_code == 15) begin
          m_entry = 0;
        end else if (exp_code == 14 && m_entry != 0) begin
          m_hist.push_front(m_entry);
          if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
          m_pend = 1;
          m_pend_val = m_entry;
          m_entry = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      hist_rd_idx = hist_rd_idx + 1'b1;
    end
  endtask

  task automatic press(input int r, input int c, input int hold);
    exp_code = key_tab[r][c];
    press_r  = r;
    press_c  = c;
    press_on = 1;
    cyc(hold);
    press_on = 0;
    cyc(12 * SCAN_DIV);
  endtask

  task automatic read_hist(input int idx, input int exp, input string nm);
    @(posedge clk);
    #1;
    hist_rd_idx = 2'(idx);
    @(negedge clk);
    chk(nm, int'(hist_rd_data), exp);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_col"}, int'(col), 15);
    chk({tag, "_key_valid"}, int'(key_valid), 0);
    chk({tag, "_key_code"}, int'(key_code), 0);
    chk({tag, "_entry"}, int'(entry), 0);
    chk({tag, "_commit_valid"}, int'(commit_valid), 0);
    chk({tag, "_commit_value"}, int'(commit_value), 0);
    chk({tag, "_hist_count"}, int'(hist_count), 0);
    chk({tag, "_hist_rd_ok"}, int'(hist_rd_ok), 0);
    chk({tag, "_hist_rd_data"}, int'(hist_rd_data), 0);
  endtask

  initial begin : stim
    int k0, c0, n;
    headroom    = 10'd999;
    hist_rd_idx = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 0;
    en  = 1;
    cyc(8);

    // 1: long hold of key 5 gives exactly one event
    k0 = kv_count;
    press(1, 1, 10 * SCAN_DIV);
    chk("t1_pulses", kv_count - k0, 1);
    chk("t1_entry", int'(entry), 5);
    press(3, 0, 60);
    chk("t1_clear", int'(entry), 0);

    // 2: row bouncing every tick never qualifies
    k0 = kv_count;
    exp_code = 5;
    press_r = 1;
    press_c = 1;
    for (int i = 0; i < 8; i++) begin
      press_on = (i % 2 == 0);
      cyc(SCAN_DIV);
    end
    press_on = 0;
    cyc(12 * SCAN_DIV);
    chk("t2_pulses", kv_count - k0, 0);
    chk("t2_entry", int'(entry), 0);
    chk("t2_idle_col", int'(col), 0);

    // 3: digit accumulation and clamping
    press(0, 0, 60);
    press(0, 1, 60);
    press(0, 2, 60);
    chk("t3_123", int'(entry), 123);
    press(1, 0, 60);
    chk("t3_clamp999", int'(entry), 999);
    press(3, 0, 60);
    headroom = 10'd100;
    press(0, 0, 60);
    press(1, 1, 60);
    chk("t3_15", int'(entry), 15);
    press(3, 1, 60);
    chk("t3_clamp100", int'(entry), 100);
    press(3, 0, 60);
    headroom = 10'd999;

    // 4: five commits into a four-deep ring
    c0 = cv_count;
    for (int k = 1; k <= 5; k++) begin
      press((k - 1) / 3, (k - 1) % 3, 60);
      press(3, 2, 60);
    end
    chk("t4_commits", cv_count - c0, 5);
    chk("t4_hist_count", int'(hist_count), 4);
    read_hist(0, 5, "t4_idx0");
    read_hist(1, 4, "t4_idx1");
    read_hist(3, 2, "t4_idx3");

    // 5: CLEAR then CONFIRM on zero, then keys ignored while disabled
    press(2, 0, 60);
    chk("t5_seven", int'(entry), 7);
    press(3, 0, 60);
    c0 = cv_count;
    press(3, 2, 60);
    chk("t5_no_commit", cv_count - c0, 0);
    chk("t5_entry", int'(entry), 0);
    en = 0;
    cyc(4);
    k0 = kv_count;
    exp_code = 8;
    press_r = 2;
    press_c = 1;
    press_on = 1;
    cyc(60);
    chk("t5_col_off", int'(col), 15);
    press_on = 0;
    cyc(8);
    en = 1;
    cyc(12 * SCAN_DIV);
    chk("t5_no_key", kv_count - k0, 0);
    chk("t5_hist_kept", int'(hist_count), 4);

    // 6: reset while a key is held in PRESSED
    exp_code = 5;
    press_r = 1;
    press_c = 1;
    press_on = 1;
    k0 = kv_count;
    n = 0;
    while (kv_count == k0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("t6_first_key_seen", (kv_count != k0) ? 1 : 0, 1);
    cyc(2);
    rst = 1;
    @(negedge clk);
    check_reset_values("t6_rst");
    cyc(3);
    rst = 0;
    k0 = kv_count;
    n = 0;
    while (kv_count == k0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("t6_key_after_rst", (kv_count != k0) ? 1 : 0, 1);
    chk("t6_waited_debounce", (n >= DEB_TICKS * SCAN_DIV) ? 1 : 0, 1);
    press_on = 0;
    cyc(12 * SCAN_DIV);
    chk("t6_pulses", kv_count - k0, 1);
    chk("t6_entry", int'(entry), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
